tile_deskew_collect: RTL and testbench

//  Receive end of the 8x8 transpose/systolic tile stream. Lane k of a row arrives k cycles after lane 0.

---
 rtl/tile_deskew_collect.sv | 162 ++++++++++++++++
 tb/tb_tile_deskew_collect.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_deskew_collect.sv
// Receive side of the 8x8 tile stream: removes the per-lane diagonal skew,
// rebuilds whole rows with their clear tags and buffers them behind a credit.
module tile_deskew_collect #(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_tag,
  output logic                   out_last,
  output logic                   overflow
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(DEPTH);
  localparam int BD = DEPTH - 1;
  localparam int EW = LANES * WIDTH + LANES + 1;

  logic [RW-1:0]          res_q, res_d;
  logic [LANES-2:0]       vld_q;
  logic [IW-1:0]          ridx_q;
  logic                   ovf_q;
  logic [EW-1:0]          buf_q [BD];
  logic [CW-1:0]          bcnt_q;
  logic [CW-1:0]          widx;
  logic [EW-1:0]          head_q, head_d;
  logic                   hv_q, hv_d;
  logic [WIDTH:0]         al [LANES];
  logic [LANES*WIDTH-1:0] row_data;
  logic [LANES-1:0]       row_tag;
  logic [EW-1:0]          wentry;
  logic                   acc, drop, wr, pop;
  logic                   bpop, bpush;

  assign in_ready = enable && (res_q < RW'(DEPTH));
  assign acc      = in_valid && in_ready;
  assign drop     = in_valid && enable && !in_ready;
  assign wr       = enable && vld_q[LANES-2];
  assign pop      = hv_q && out_ready;

  // Lane k waits LANES-1-k enabled cycles so every lane meets the last one.
  for (genvar k = 0; k < LANES - 1; k++) begin : g_skew
    localparam int N = LANES - 1 - k;
    logic [WIDTH:0] p_q [N];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < N; i++) p_q[i] <= '0;
      end else if (enable) begin
        p_q[0] <= {in_tag[k], in_data[k*WIDTH +: WIDTH]};
        for (int i = 1; i < N; i++) p_q[i] <= p_q[i-1];
      end
    end

    assign al[k] = p_q[N-1];
  end

  assign al[LANES-1] = {in_tag[LANES-1],
                        in_data[(LANES-1)*WIDTH +: WIDTH]};

  always_comb begin
    row_data = '0;
    row_tag  = '0;
    for (int k = 0; k < LANES; k++) begin
      row_data[k*WIDTH +: WIDTH] = al[k][WIDTH-1:0];
      row_tag[k]                 = al[k][WIDTH];
    end
  end

  assign wentry = {ridx_q == IW'(LANES - 1), row_tag, row_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else if (enable) begin
      vld_q[0] <= acc;
      for (int i = 1; i < LANES - 1; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_comb begin
    res_d = res_q;
    unique case ({acc, pop})
      2'b10:   res_d = res_q + RW'(1);
      2'b01:   res_d = res_q - RW'(1);
      default: res_d = res_q;
    endcase
  end

  // Head register refills from the buffer first, else straight from the
  // aligner, so row order is kept and an empty FIFO costs no extra cycle.
  always_comb begin
    hv_d   = hv_q;
    head_d = head_q;
    bpop   = 1'b0;
    bpush  = wr;
    if (!hv_q || pop) begin
      if (bcnt_q != '0) begin
        hv_d   = 1'b1;
        head_d = buf_q[0];
        bpop   = 1'b1;
      end else if (wr) begin
        hv_d   = 1'b1;
        head_d = wentry;
        bpush  = 1'b0;
      end else begin
        hv_d   = 1'b0;
      end
    end
  end

  assign widx = bpop ? bcnt_q - CW'(1) : bcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
      for (int i = 0; i < BD; i++) buf_q[i] <= '0;
    end else begin
      if (bpop) begin
        for (int i = 0; i < BD - 1; i++) buf_q[i] <= buf_q[i+1];
      end
      if (bpush) buf_q[widx] <= wentry;
      if (bpush && !bpop)      bcnt_q <= bcnt_q + CW'(1);
      else if (bpop && !bpush) bcnt_q <= bcnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      ridx_q <= '0;
      ovf_q  <= 1'b0;
      hv_q   <= 1'b0;
      head_q <= '0;
    end else begin
      res_q  <= res_d;
      hv_q   <= hv_d;
      head_q <= head_d;
      if (drop) ovf_q <= 1'b1;
      if (wr) begin
        ridx_q <= (ridx_q == IW'(LANES - 1)) ? '0 : ridx_q + IW'(1);
      end
    end
  end

  assign out_valid = hv_q;
  assign out_last  = head_q[EW-1];
  assign out_tag   = head_q[LANES*WIDTH +: LANES];
  assign out_data  = head_q[LANES*WIDTH-1:0];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_tile_deskew_collect.sv
// Bench for tile_deskew_collect: skewed source, queue-based row model,
// directed scenarios plus a randomized run.
module tb_tile_deskew_collect;

  localparam int LANES = 8;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int DW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          reset, enable, in_valid, in_ready;
  logic          out_valid, out_ready, out_last, overflow;
  logic [DW-1:0] in_data, out_data;
  logic [LANES-1:0] in_tag, out_tag;

  typedef struct {
    logic [DW-1:0]    d;
    logic [LANES-1:0] t;
    int               e;
    logic             last;
  } row_t;

  row_t             infl[$];
  row_t             fifo[$];
  logic [DW-1:0]    off_d [int];
  logic [LANES-1:0] off_t [int];
  int               E = 0;
  int               m_res, m_ridx;
  logic             m_ovf;

  logic             exp_valid, exp_ready, exp_ovf, exp_l;
  logic [DW-1:0]    exp_d;
  logic [LANES-1:0] exp_t;
  logic             p_acc, p_drop, p_pop, p_wr, p_en;

  int n_chk = 0;
  int n_fail = 0;

  tile_deskew_collect #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_row();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = $urandom;
    return r;
  endfunction

  // Source side: lane k carries the row offered k enabled cycles earlier.
  // Model side: rows land in the FIFO LANES-1 enabled cycles after accept.
  task automatic drive(input logic v, input logic en, input logic ordy,
                       input logic [DW-1:0] d, input logic [LANES-1:0] t);
    logic [DW-1:0] od;
    logic [LANES-1:0] ot;
    reset = 1'b0; enable = en; in_valid = v; out_ready = ordy;
    if (v && en) begin
      off_d[E] = d;
      off_t[E] = t;
    end
    for (int k = 0; k < LANES; k++) begin
      if (off_d.exists(E - k)) begin
        od = off_d[E - k];
        ot = off_t[E - k];
        in_data[k*WIDTH +: WIDTH] = od[k*WIDTH +: WIDTH];
        in_tag[k] = ot[k];
      end else begin
        in_data[k*WIDTH +: WIDTH] = $urandom;
        in_tag[k] = 1'($urandom);
      end
    end
    exp_ready = en && (m_res < DEPTH);
    exp_valid = fifo.size() > 0;
    exp_ovf   = m_ovf;
    exp_d = '0; exp_t = '0; exp_l = 1'b0;
    if (exp_valid) begin
      exp_d = fifo[0].d; exp_t = fifo[0].t; exp_l = fifo[0].last;
    end
    p_en   = en;
    p_acc  = v && exp_ready;
    p_drop = v && en && !exp_ready;
    p_pop  = exp_valid && ordy;
    p_wr   = en && infl.size() > 0 && (infl[0].e + LANES - 1 == E);
    #1;
  endtask

  task automatic advance();
    row_t r;
    @(posedge clk);
    if (p_drop) m_ovf = 1'b1;
    if (p_pop) void'(fifo.pop_front());
    if (p_wr) begin
      r = infl.pop_front();
      r.last = (m_ridx == LANES - 1);
      m_ridx = (m_ridx + 1) % LANES;
      fifo.push_back(r);
    end
    if (p_acc) begin
      r.d = off_d[E]; r.t = off_t[E]; r.e = E; r.last = 1'b0;
      infl.push_back(r);
    end
    m_res = m_res + int'(p_acc) - int'(p_pop);
    if (p_en) E++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tag = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    infl.delete(); fifo.delete(); off_d.delete(); off_t.delete();
    m_res = 0; m_ovf = 1'b0; m_ridx = 0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0, '0);
    n_chk++;
    if ({out_valid, out_last, overflow, out_tag, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b l=%b o=%b t=%h d=%h want all 0",
               out_valid, out_last, overflow, out_tag, out_data);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    advance();
  endtask

  task automatic test_single_row();
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      drive(c == 0, 1'b1, 1'b1, d, 8'h08);
      n_chk++;
      if (out_valid !== (c == 8)) begin
        n_fail++;
        $display("FAIL t1_valid c=%0d: got %b want %b", c, out_valid, c == 8);
      end
      if (c == 8) begin
        n_chk++;
        if ({out_data, out_tag, out_last} !== {d, 8'h08, 1'b0}) begin
          n_fail++;
          $display("FAIL t1_row: got %h/%h/%b want %h/08/0",
                   out_data, out_tag, out_last, d);
        end
      end
      advance();
    end
  endtask

  // Rows are re-offered while credit is short, so all 8 rows form one tile.
  task automatic test_full_tile();
    logic [DW-1:0]    rows [LANES];
    logic [LANES-1:0] tags [LANES];
    int acc_n = 0;
    int out_n = 0;
    for (int r = 0; r < LANES; r++) begin
      for (int k = 0; k < LANES; k++) rows[r][k*WIDTH +: WIDTH] = r * 16 + k;
      tags[r] = LANES'($urandom);
    end
    do_reset();
    for (int c = 0; c < 40; c++) begin
      drive(acc_n < LANES, 1'b1, 1'b1, rows[acc_n % LANES], tags[acc_n % LANES]);
      n_chk++;
      if (in_ready !== exp_ready || out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL t2_hs c=%0d: got rdy=%b vld=%b want rdy=%b vld=%b",
                 c, in_ready, out_valid, exp_ready, exp_valid);
      end
      if (c < DEPTH) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL t2_credit c=%0d: got %b want 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1 && out_n < LANES) begin
        n_chk++;
        if ({out_data, out_tag, out_last} !==
            {rows[out_n], tags[out_n], out_n == LANES - 1}) begin
          n_fail++;
          $display("FAIL t2_row %0d: got %h/%h/%b want %h/%h/%b", out_n,
                   out_data, out_tag, out_last, rows[out_n], tags[out_n],
                   out_n == LANES - 1);
        end
        out_n++;
      end
      if (acc_n < LANES && exp_ready) acc_n++;
      advance();
    end
    n_chk++;
    if (out_n != LANES) begin
      n_fail++;
      $display("FAIL t2_count: got %0d want %0d", out_n, LANES);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0]    rows [6];
    logic [LANES-1:0] tags [6];
    int got = 0;
    for (int r = 0; r < 6; r++) begin
      rows[r] = rnd_row();
      tags[r] = LANES'($urandom);
    end
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c < 6, 1'b1, 1'b0, rows[c % 6], tags[c % 6]);
      if (c < 6) begin
        n_chk++;
        if (in_ready !== (c < DEPTH)) begin
          n_fail++;
          $display("FAIL t3_ready c=%0d: got %b want %b", c, in_ready, c < DEPTH);
        end
      end
      if (c >= 5) begin
        n_chk++;
        if (overflow !== 1'b1) begin
          n_fail++;
          $display("FAIL t3_ovf c=%0d: got %b want 1", c, overflow);
        end
      end
      n_chk++;
      if (out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL t3_valid c=%0d: got %b want %b", c, out_valid, exp_valid);
      end
      advance();
    end
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 1'b1, '0, '0);
      if (out_valid === 1'b1) begin
        n_chk++;
        if (got >= DEPTH || {out_data, out_tag} !== {rows[got], tags[got]}) begin
          n_fail++;
          $display("FAIL t3_drain %0d: got %h want %h", got, out_data, rows[got]);
        end
        got++;
      end
      advance();
    end
    n_chk++;
    if (got != DEPTH) begin
      n_fail++;
      $display("FAIL t3_count: got %0d want %0d", got, DEPTH);
    end
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0, '0);
    n_chk++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_clear: got ovf=%b vld=%b want 0/0", overflow, out_valid);
    end
    advance();
  endtask

  task automatic test_accept_pop();
    logic [DW-1:0]    rows [5];
    logic [LANES-1:0] tags [5];
    int got = 0;
    for (int r = 0; r < 5; r++) begin
      rows[r] = rnd_row();
      tags[r] = LANES'($urandom);
    end
    do_reset();
    for (int c = 0; c < 11; c++) begin
      drive(c < 3, 1'b1, 1'b0, rows[c % 3], tags[c % 3]);
      advance();
    end
    drive(1'b1, 1'b1, 1'b1, rows[3], tags[3]);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== rows[0]) begin
      n_fail++;
      $display("FAIL t4_both: got rdy=%b vld=%b d=%h want 1/1/%h",
               in_ready, out_valid, out_data, rows[0]);
    end
    got = 1;
    advance();
    drive(1'b1, 1'b1, 1'b0, rows[4], tags[4]);
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_res3: got rdy=%b want 1", in_ready);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_res4: got rdy=%b want 0", in_ready);
    end
    advance();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b1, 1'b1, '0, '0);
      if (out_valid === 1'b1) begin
        n_chk++;
        if (got >= 5 || {out_data, out_tag} !== {rows[got % 5], tags[got % 5]}) begin
          n_fail++;
          $display("FAIL t4_drain %0d: got %h want %h", got, out_data, rows[got % 5]);
        end
        got++;
      end
      advance();
    end
    n_chk++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL t4_count: got %0d want 5", got);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0]    d;
    logic [LANES-1:0] t;
    d = rnd_row();
    t = LANES'($urandom);
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      drive(c == 0, !(c >= 3 && c <= 5), 1'b1, d, t);
      n_chk++;
      if (out_valid !== (c == 11)) begin
        n_fail++;
        $display("FAIL t5_valid c=%0d: got %b want %b", c, out_valid, c == 11);
      end
      if (c == 11) begin
        n_chk++;
        if ({out_data, out_tag} !== {d, t}) begin
          n_fail++;
          $display("FAIL t5_row: got %h/%h want %h/%h", out_data, out_tag, d, t);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_tile();
    logic [DW-1:0]    d;
    logic [LANES-1:0] t;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b1, rnd_row(), LANES'($urandom));
      advance();
    end
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0, '0);
    n_chk++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after: got vld=%b ovf=%b want 0/0", out_valid, overflow);
    end
    advance();
    d = rnd_row();
    t = LANES'($urandom);
    for (int c = 0; c <= 11; c++) begin
      drive(c == 0, 1'b1, 1'b1, d, t);
      n_chk++;
      if (out_valid !== (c == 8)) begin
        n_fail++;
        $display("FAIL t6_valid c=%0d: got %b want %b", c, out_valid, c == 8);
      end
      if (c == 8) begin
        n_chk++;
        if ({out_data, out_tag, out_last} !== {d, t, 1'b0}) begin
          n_fail++;
          $display("FAIL t6_row: got %h/%h/%b want %h/%h/0",
                   out_data, out_tag, out_last, d, t);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic v, en, ordy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 7) != 0);
      ordy = ((c / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 3) != 0);
      drive(v, en, ordy, rnd_row(), LANES'($urandom));
      n_chk++;
      if (out_valid !== exp_valid || in_ready !== exp_ready ||
          overflow !== exp_ovf) begin
        n_fail++;
        $display("FAIL rnd_ctl c=%0d: got v=%b r=%b o=%b want v=%b r=%b o=%b",
                 c, out_valid, in_ready, overflow, exp_valid, exp_ready, exp_ovf);
      end
      if (exp_valid) begin
        n_chk++;
        if ({out_data, out_tag, out_last} !== {exp_d, exp_t, exp_l}) begin
          n_fail++;
          $display("FAIL rnd_row c=%0d: got %h/%h/%b want %h/%h/%b", c,
                   out_data, out_tag, out_last, exp_d, exp_t, exp_l);
        end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tag = '0;
    m_res = 0; m_ridx = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_row();
    test_full_tile();
    test_backpressure();
    test_accept_pop();
    test_stall();
    test_reset_mid_tile();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
